// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// Takes one bit per CONV cycle and saturates to all nines when the input has more decimal digits than the output.
module bin_to_bcd_seq #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_bin;
  logic [BCD_W-1:0]  r_scratch;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_pend;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_ovf;

  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_scratch_next;
  logic [DATA_W-1:0] w_bin_next;
  logic [63:0]       w_bin_ext;
  logic              w_in_ovf;
  logic              w_last;
  logic              w_accept;

  // Add 3 to every digit >= 5 so the following left shift carries correctly into the next decade.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) : r_scratch[4*gi +: 4];
    end
  endgenerate

  assign w_scratch_next = {w_adj[BCD_W-2:0], r_bin[DATA_W-1]};
  assign w_bin_next     = {r_bin[DATA_W-2:0], 1'b0};
  assign w_last         = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_bin_ext      = 64'(bin_in);
  assign w_in_ovf       = (w_bin_ext > MAX_VAL);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = CONV;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Overflow is decided at acceptance, because the binary shift register is consumed during CONV.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_bin      <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_bin      <= bin_in;
        r_scratch  <= '0;
        r_cnt      <= '0;
        r_ovf_pend <= w_in_ovf;
      end else if (r_state == CONV) begin
        r_bin     <= w_bin_next;
        r_scratch <= w_scratch_next;
        r_cnt     <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_bcd <= r_ovf_pend ? ALL_NINES : w_scratch_next;
          r_ovf <= r_ovf_pend;
        end
      end
    end
  end

  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and swept checks for bin_to_bcd_seq: latency, busy/done windows, saturation, reset abort.
module tb_bin_to_bcd_seq;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic [19:0] bin_in;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;

  int n_checks;
  int n_pass;

  bin_to_bcd_seq #(.DATA_W(20), .DIGITS(6)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Decimal reference by repeated division, saturating above 999999.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    r = '0;
    if (v > 999999) begin
      r = 24'h999999;
    end else begin
      x = v;
      for (int d = 0; d < 6; d++) begin
        r[4*d +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // Called at a negedge; cycle 0 is the current cycle. Returns at the negedge of cycle 22.
  task automatic run_conv(input logic [19:0] v, input logic [19:0] v_after,
                          input int restart_cyc, input logic [19:0] restart_val,
                          input bit hold,
                          output int done_cyc, output int done_cnt, output int busy_bad,
                          output logic [23:0] done_bcd, output logic done_ovf);
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    done_bcd = 'x;
    done_ovf = 1'bx;
    start  = 1'b1;
    bin_in = v;
    for (int c = 1; c <= 22; c++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          done_bcd = bcd_out;
          done_ovf = ovf;
        end
      end
      if (busy !== ((c <= 21) ? 1'b1 : 1'b0)) busy_bad++;
      start = hold || (c == restart_cyc);
      if (c == 1) bin_in = v_after;
      if (c == restart_cyc) bin_in = restart_val;
    end
    $display("conv in=%0d done_cyc=%0d dones=%0d bcd=%06h ovf=%0b", v, done_cyc, done_cnt, done_bcd, done_ovf);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    start   = 1'b0;
    bin_in  = '0;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_checks++; if (bcd_out !== 24'h0) $display("FAIL reset_bcd got=%06h want=000000", bcd_out); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b want=0", ovf); else n_pass++;
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic test_zero();
    int dc, dn, bb; logic [23:0] b; logic o;
    run_conv(20'd0, 20'd0, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (dc !== 21) $display("FAIL zero_done_cycle got=%0d want=21", dc); else n_pass++;
    n_checks++; if (dn !== 1) $display("FAIL zero_done_count got=%0d want=1", dn); else n_pass++;
    n_checks++; if (bb !== 0) $display("FAIL zero_busy_window got=%0d bad cycles want=0", bb); else n_pass++;
    n_checks++; if (b !== 24'h000000) $display("FAIL zero_bcd got=%06h want=000000", b); else n_pass++;
    n_checks++; if (o !== 1'b0) $display("FAIL zero_ovf got=%b want=0", o); else n_pass++;
  endtask

  task automatic test_latch();
    int dc, dn, bb; logic [23:0] b; logic o;
    run_conv(20'd123456, 20'd7, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (dc !== 21) $display("FAIL latch_done_cycle got=%0d want=21", dc); else n_pass++;
    n_checks++; if (bb !== 0) $display("FAIL latch_busy_window got=%0d bad cycles want=0", bb); else n_pass++;
    n_checks++; if (b !== 24'h123456) $display("FAIL latch_bcd got=%06h want=123456", b); else n_pass++;
    n_checks++; if (o !== 1'b0) $display("FAIL latch_ovf got=%b want=0", o); else n_pass++;
  endtask

  task automatic test_overflow();
    int dc, dn, bb; logic [23:0] b; logic o;
    run_conv(20'd999999, 20'd999999, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (b !== 24'h999999) $display("FAIL max_bcd got=%06h want=999999", b); else n_pass++;
    n_checks++; if (o !== 1'b0) $display("FAIL max_ovf got=%b want=0", o); else n_pass++;
    run_conv(20'd1000000, 20'd1000000, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (b !== 24'h999999) $display("FAIL ovf1_bcd got=%06h want=999999", b); else n_pass++;
    n_checks++; if (o !== 1'b1) $display("FAIL ovf1_ovf got=%b want=1", o); else n_pass++;
    run_conv(20'hFFFFF, 20'hFFFFF, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (b !== 24'h999999) $display("FAIL ovfmax_bcd got=%06h want=999999", b); else n_pass++;
    n_checks++; if (o !== 1'b1) $display("FAIL ovfmax_ovf got=%b want=1", o); else n_pass++;
    bin_in = 20'd5;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (bcd_out !== 24'h999999) $display("FAIL hold_bcd got=%06h want=999999", bcd_out); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL hold_ovf got=%b want=1", ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int dc, dn, bb; logic [23:0] b; logic o;
    run_conv(20'd42, 20'd42, 10, 20'd77, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (dn !== 1) $display("FAIL ignore_done_count got=%0d want=1", dn); else n_pass++;
    n_checks++; if (bb !== 0) $display("FAIL ignore_busy_window got=%0d bad cycles want=0", bb); else n_pass++;
    n_checks++; if (b !== 24'h000042) $display("FAIL ignore_bcd got=%06h want=000042", b); else n_pass++;
    run_conv(20'd77, 20'd77, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (dc !== 21) $display("FAIL second_done_cycle got=%0d want=21 (cycle 43 overall)", dc); else n_pass++;
    n_checks++; if (b !== 24'h000077) $display("FAIL second_bcd got=%06h want=000077", b); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, dn, bb; logic [23:0] b; logic o;
    run_conv(20'd5, 20'd5, 0, 20'd0, 1'b1, dc, dn, bb, b, o);
    n_checks++; if (dn !== 1 || dc !== 21) $display("FAIL hold1_done got=%0d@%0d want=1@21", dn, dc); else n_pass++;
    n_checks++; if (b !== 24'h000005) $display("FAIL hold1_bcd got=%06h want=000005", b); else n_pass++;
    run_conv(20'd98765, 20'd98765, 0, 20'd0, 1'b1, dc, dn, bb, b, o);
    n_checks++; if (dn !== 1 || dc !== 21) $display("FAIL hold2_done got=%0d@%0d want=1@21", dn, dc); else n_pass++;
    n_checks++; if (b !== 24'h098765) $display("FAIL hold2_bcd got=%06h want=098765", b); else n_pass++;
    run_conv(20'd31, 20'd31, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (bb !== 0) $display("FAIL hold3_busy_window got=%0d bad cycles want=0", bb); else n_pass++;
    n_checks++; if (b !== 24'h000031) $display("FAIL hold3_bcd got=%06h want=000031", b); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dc, dn, bb, nd, nb; logic [23:0] b; logic o;
    start  = 1'b1;
    bin_in = 20'd654321;
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      start = 1'b0;
    end
    sys_rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy); else n_pass++;
    n_checks++; if (bcd_out !== 24'h0) $display("FAIL rstmid_bcd got=%06h want=000000", bcd_out); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done got=%b want=0", done); else n_pass++;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    nd = 0;
    nb = 0;
    repeat (25) begin
      @(negedge sys_clk);
      if (done !== 1'b0) nd++;
      if (busy !== 1'b0) nb++;
    end
    n_checks++; if (nd !== 0 || nb !== 0) $display("FAIL rstmid_abort got done=%0d busy=%0d cycles want=0/0", nd, nb); else n_pass++;
    n_checks++; if (bcd_out !== 24'h0) $display("FAIL rstmid_bcd_after got=%06h want=000000", bcd_out); else n_pass++;
    run_conv(20'd654321, 20'd654321, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
    n_checks++; if (dc !== 21) $display("FAIL rstmid_restart_cycle got=%0d want=21", dc); else n_pass++;
    n_checks++; if (b !== 24'h654321) $display("FAIL rstmid_restart_bcd got=%06h want=654321", b); else n_pass++;
  endtask

  task automatic test_sweep();
    int dc, dn, bb, bad_nib; logic [23:0] b, exp_b; logic o;
    logic [19:0] v;
    for (int i = 0; i < 1000; i++) begin
      v = 20'($urandom_range(0, 20'hFFFFF));
      run_conv(v, ~v, 0, 20'd0, 1'b0, dc, dn, bb, b, o);
      exp_b = ref_bcd(32'(v));
      bad_nib = 0;
      for (int d = 0; d < 6; d++) if (b[4*d +: 4] > 4'd9) bad_nib++;
      n_checks++; if (b !== exp_b) $display("FAIL sweep_bcd in=%0d got=%06h want=%06h", v, b, exp_b); else n_pass++;
      n_checks++; if (o !== (v > 20'd999999)) $display("FAIL sweep_ovf in=%0d got=%b want=%b", v, o, (v > 20'd999999)); else n_pass++;
      n_checks++; if (dc !== 21) $display("FAIL sweep_done_cycle in=%0d got=%0d want=21", v, dc); else n_pass++;
      n_checks++; if (bad_nib !== 0) $display("FAIL sweep_nibble in=%0d got=%0d bad nibbles want=0", v, bad_nib); else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_zero();
    test_latch();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
